// File: rtl/token_lexer_if.sv
// Byte-in / token-out bus of the lexer. The master modport is the lexer
// (byte consumer, token producer); the slave modport is the source/parser side.
interface token_lexer_if;
  logic        I_CHAR_VALID;
  logic [7:0]  I_CHAR;
  logic        O_CHAR_READY;
  logic        O_VALID;
  logic [15:0] O_TOKEN;
  logic        RECEIVE;
  logic        O_DONE;
  logic        O_ERROR;

  modport master (
    input  I_CHAR_VALID, I_CHAR, RECEIVE,
    output O_CHAR_READY, O_VALID, O_TOKEN, O_DONE, O_ERROR
  );

  modport slave (
    output I_CHAR_VALID, I_CHAR, RECEIVE,
    input  O_CHAR_READY, O_VALID, O_TOKEN, O_DONE, O_ERROR
  );
endinterface

// File: rtl/token_lexer.sv
// Character-stream lexer: groups decimal digits into 8-bit NUM tokens and emits
// PLUS/MUL/EOF tokens. Define TOKEN_LEXER_SAT_EN to clamp numbers at 8'hFF instead of wrapping.
module token_lexer #(
  parameter logic [7:0] EOF_CHAR   = 8'h0A,
  parameter logic [7:0] SPACE_CHAR = 8'h20
) (
  input logic          CLK,
  input logic          RST,
  token_lexer_if.master bus
);

`ifdef TOKEN_LEXER_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [1:0] KIND_NUM  = 2'd0;
  localparam logic [1:0] KIND_PLUS = 2'd1;
  localparam logic [1:0] KIND_MUL  = 2'd2;
  localparam logic [1:0] KIND_EOF  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_NUM, S_WAIT, S_WAIT_PEND, S_WAIT_EOF, S_DONE, S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  acc_q, acc_d;
  logic [1:0]  pend_q, pend_d;
  logic        valid_q, valid_d;
  logic [15:0] token_q, token_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        char_ready;
  logic        xfer;
  logic        is_digit, is_space, is_plus, is_mul, is_eof, is_term;
  logic [7:0]  digit;
  logic [11:0] acc_mul;
  logic [7:0]  acc_step;
  logic [1:0]  term_kind;

  // Character classification and accumulator arithmetic
  always_comb begin
    is_digit  = (bus.I_CHAR >= 8'h30) && (bus.I_CHAR <= 8'h39);
    is_space  = (bus.I_CHAR == SPACE_CHAR);
    is_plus   = (bus.I_CHAR == 8'h2B);
    is_mul    = (bus.I_CHAR == 8'h2A);
    is_eof    = (bus.I_CHAR == EOF_CHAR);
    is_term   = is_plus || is_mul || is_eof;
    term_kind = is_plus ? KIND_PLUS : (is_mul ? KIND_MUL : KIND_EOF);
    digit     = bus.I_CHAR - 8'h30;
    acc_mul   = ({4'b0, acc_q} * 12'd10) + {4'b0, digit};
    // Any bit above the low byte means the value no longer fits in 8 bits
    acc_step  = (SAT_EN && (|acc_mul[11:8])) ? 8'hFF : acc_mul[7:0];
    xfer      = bus.I_CHAR_VALID && char_ready;
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      acc_q   <= 8'h00;
      pend_q  <= KIND_NUM;
      valid_q <= 1'b0;
      token_q <= 16'h0000;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      token_q <= token_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (xfer) begin
        if (is_digit)                  state_d = S_NUM;
        else if (is_space)             state_d = S_IDLE;
        else if (is_plus || is_mul)    state_d = S_WAIT;
        else if (is_eof)               state_d = S_WAIT_EOF;
        else                           state_d = S_ERROR;
      end
      S_NUM: if (xfer) begin
        if (is_digit)                  state_d = S_NUM;
        else if (is_space)             state_d = S_WAIT;
        else if (is_term)              state_d = S_WAIT_PEND;
        else                           state_d = S_ERROR;
      end
      S_WAIT:      if (bus.RECEIVE) state_d = S_IDLE;
      S_WAIT_PEND: if (bus.RECEIVE) state_d = (pend_q == KIND_EOF) ? S_WAIT_EOF : S_WAIT;
      S_WAIT_EOF:  if (bus.RECEIVE) state_d = S_DONE;
      S_DONE:      state_d = S_DONE;
      S_ERROR:     state_d = S_ERROR;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic; the ready flag depends on state alone
  always_comb begin
    char_ready = (state_q == S_IDLE) || (state_q == S_NUM);
    acc_d      = acc_q;
    pend_d     = pend_q;
    valid_d    = valid_q;
    token_d    = token_q;
    done_d     = done_q;
    error_d    = error_q;
    case (state_q)
      S_IDLE: if (xfer) begin
        if (is_digit) begin
          acc_d = digit;
        end else if (is_space) begin
          acc_d = acc_q;
        end else if (is_plus || is_mul) begin
          token_d = {6'b0, term_kind, 8'h00};
          valid_d = 1'b1;
        end else if (is_eof) begin
          token_d = 16'h0300;
          valid_d = 1'b1;
        end else begin
          error_d = 1'b1;
          valid_d = 1'b0;
        end
      end
      S_NUM: if (xfer) begin
        if (is_digit) begin
          acc_d = acc_step;
        end else if (is_space || is_term) begin
          token_d = {6'b0, KIND_NUM, acc_q};
          valid_d = 1'b1;
          if (!is_space) pend_d = term_kind;
        end else begin
          error_d = 1'b1;
          valid_d = 1'b0;
        end
      end
      S_WAIT: if (bus.RECEIVE) valid_d = 1'b0;
      // Pending terminator replaces the number on the same edge, valid stays high
      S_WAIT_PEND: if (bus.RECEIVE) token_d = {6'b0, pend_q, 8'h00};
      S_WAIT_EOF: if (bus.RECEIVE) begin
        valid_d = 1'b0;
        done_d  = 1'b1;
      end
      S_ERROR: begin
        error_d = 1'b1;
        valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.O_CHAR_READY = char_ready;
  assign bus.O_VALID      = valid_q;
  assign bus.O_TOKEN      = token_q;
  assign bus.O_DONE       = done_q;
  assign bus.O_ERROR      = error_q;

endmodule

// File: tb/tb_token_lexer.sv
// Directed bench for token_lexer: drives byte strings, pulses RECEIVE and
// compares each token and status flag against hand-computed values.
module tb_token_lexer;

  logic CLK = 1'b0;
  logic RST;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 CLK = ~CLK;

  token_lexer_if bus ();

  token_lexer dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic send_char(input logic [7:0] c);
    int i;
    for (i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (bus.O_CHAR_READY === 1'b1) break;
    end
    if (i == 20) chk("ready_timeout", {15'b0, bus.O_CHAR_READY}, 16'h0001);
    bus.I_CHAR_VALID = 1'b1;
    bus.I_CHAR       = c;
    @(posedge CLK);
    #1 bus.I_CHAR_VALID = 1'b0;
    $display("sent byte %h", c);
  endtask

  task automatic expect_token(input string tag, input logic [15:0] exp);
    int i;
    for (i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (bus.O_VALID === 1'b1) break;
    end
    chk({tag, "_valid"}, {15'b0, bus.O_VALID}, 16'h0001);
    chk(tag, bus.O_TOKEN, exp);
    $display("token %s: got %h want %h", tag, bus.O_TOKEN, exp);
    bus.RECEIVE = 1'b1;
    @(posedge CLK);
    #1 bus.RECEIVE = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int k = 0; k < s.len(); k++) send_char(s[k]);
  endtask

  initial begin
    RST              = 1'b1;
    bus.I_CHAR_VALID = 1'b0;
    bus.I_CHAR       = 8'h00;
    bus.RECEIVE      = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    chk("rst_valid", {15'b0, bus.O_VALID}, 16'h0000);
    chk("rst_token", bus.O_TOKEN, 16'h0000);
    chk("rst_done",  {15'b0, bus.O_DONE}, 16'h0000);
    chk("rst_error", {15'b0, bus.O_ERROR}, 16'h0000);
    chk("rst_ready", {15'b0, bus.O_CHAR_READY}, 16'h0001);
    RST = 1'b0;

    // RECEIVE with nothing pending does nothing
    @(negedge CLK);
    bus.RECEIVE = 1'b1;
    @(posedge CLK);
    #1 bus.RECEIVE = 1'b0;
    chk("idle_rx_valid", {15'b0, bus.O_VALID}, 16'h0000);
    chk("idle_rx_ready", {15'b0, bus.O_CHAR_READY}, 16'h0001);

    // "12+3\n"
    send_str("12+");
    chk("t1_latency", {15'b0, bus.O_VALID}, 16'h0001);
    expect_token("t1_num12", 16'h000C);
    chk("t1_b2b_valid", {15'b0, bus.O_VALID}, 16'h0001);
    expect_token("t1_plus", 16'h0100);
    send_str("3\n");
    expect_token("t1_num3", 16'h0003);
    expect_token("t1_eof", 16'h0300);
    chk("t1_done",  {15'b0, bus.O_DONE}, 16'h0001);
    chk("t1_error", {15'b0, bus.O_ERROR}, 16'h0000);
    chk("t1_valid_off", {15'b0, bus.O_VALID}, 16'h0000);
    chk("t1_ready_off", {15'b0, bus.O_CHAR_READY}, 16'h0000);

    // "7 * 8\n"
    do_reset();
    send_str("7 ");
    expect_token("t2_num7", 16'h0007);
    send_char(8'h20);
    chk("t2_space_notok", {15'b0, bus.O_VALID}, 16'h0000);
    send_char(8'h2A);
    expect_token("t2_mul", 16'h0200);
    send_str(" 8\n");
    expect_token("t2_num8", 16'h0008);
    expect_token("t2_eof", 16'h0300);
    chk("t2_done", {15'b0, bus.O_DONE}, 16'h0001);

    // Backpressure on "5+"
    do_reset();
    send_str("5+");
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      chk("t3_hold_token", bus.O_TOKEN, 16'h0005);
      chk("t3_hold_valid", {15'b0, bus.O_VALID}, 16'h0001);
      chk("t3_hold_ready", {15'b0, bus.O_CHAR_READY}, 16'h0000);
    end
    @(negedge CLK);
    bus.RECEIVE = 1'b1;
    @(posedge CLK);
    #1 bus.RECEIVE = 1'b0;
    chk("t3_next_token", bus.O_TOKEN, 16'h0100);
    chk("t3_next_valid", {15'b0, bus.O_VALID}, 16'h0001);
    expect_token("t3_plus", 16'h0100);
    chk("t3_after_valid", {15'b0, bus.O_VALID}, 16'h0000);
    chk("t3_after_ready", {15'b0, bus.O_CHAR_READY}, 16'h0001);

    // "300\n" overflow
    do_reset();
    send_str("300\n");
`ifdef TOKEN_LEXER_SAT_EN
    expect_token("t4_num300", 16'h00FF);
`else
    expect_token("t4_num300", 16'h002C);
`endif
    expect_token("t4_eof", 16'h0300);
    chk("t4_done", {15'b0, bus.O_DONE}, 16'h0001);

    // Leading zeros
    do_reset();
    send_str("007 ");
    expect_token("t5_num007", 16'h0007);

    // "4a" illegal character
    do_reset();
    send_char(8'h34);
    chk("t6_no_tok_4", {15'b0, bus.O_VALID}, 16'h0000);
    send_char(8'h61);
    chk("t6_error", {15'b0, bus.O_ERROR}, 16'h0001);
    chk("t6_valid", {15'b0, bus.O_VALID}, 16'h0000);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("t6_hold_ready", {15'b0, bus.O_CHAR_READY}, 16'h0000);
      chk("t6_hold_valid", {15'b0, bus.O_VALID}, 16'h0000);
      chk("t6_hold_error", {15'b0, bus.O_ERROR}, 16'h0001);
    end

    // Reset while a token is outstanding
    do_reset();
    send_str("9+");
    chk("t7_valid_before", {15'b0, bus.O_VALID}, 16'h0001);
    do_reset();
    chk("t7_rst_valid", {15'b0, bus.O_VALID}, 16'h0000);
    chk("t7_rst_token", bus.O_TOKEN, 16'h0000);
    chk("t7_rst_done",  {15'b0, bus.O_DONE}, 16'h0000);
    chk("t7_rst_error", {15'b0, bus.O_ERROR}, 16'h0000);
    chk("t7_rst_ready", {15'b0, bus.O_CHAR_READY}, 16'h0001);
    send_str("1\n");
    expect_token("t7_num1", 16'h0001);
    expect_token("t7_eof", 16'h0300);
    chk("t7_done", {15'b0, bus.O_DONE}, 16'h0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
